// File: rtl/smvm_pkg.sv
// ---------------------------------------------------------------------------------------------
// smvm_pkg
// Shared defaults and FSM state type for the sparse matrix-vector row accumulator
// (row_accum_arbiter and its rr_arbiter sub-module).
//   NUM_CHANNELS_DEF : default number of product requesters
//   NUM_ROWS_DEF     : default accumulator depth
//   DATA_W_DEF       : default product/accumulator width
//   ROW_ID_W         : width of each requester's destination row index
//   state_e          : IDLE / CLEAR / ACCUM / DONE
// ---------------------------------------------------------------------------------------------
package smvm_pkg;

   localparam int unsigned NUM_CHANNELS_DEF = 4;
   localparam int unsigned NUM_ROWS_DEF     = 64;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned ROW_ID_W         = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StClear = 2'd1,
      StAccum = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector: grants the first requesting channel at or after
// the pointer, wrapping around. Grant is all-zero when nothing requests.
//   i_req [NUM_CHANNELS] : per-channel request
//   i_ptr [PTR_W]        : channel with highest priority this cycle
//   o_gnt [NUM_CHANNELS] : one-hot grant (or zero)
// ---------------------------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned PTR_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic [NUM_CHANNELS-1:0] i_req,
   input  logic [PTR_W-1:0]        i_ptr,
   output logic [NUM_CHANNELS-1:0] o_gnt
);

   int unsigned w_pos;
   logic        w_found;

   // Walk channels in priority order starting at the pointer; first hit wins.
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         w_pos = (32'(i_ptr) + 32'(k)) % NUM_CHANNELS;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (!w_found && (w_pos == 32'(c)) && i_req[c]) begin
               o_gnt[c] = 1'b1;
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/row_accum_arbiter.sv
// ---------------------------------------------------------------------------------------------
// row_accum_arbiter
// Round-robin arbitrates signed partial products from NUM_CHANNELS requesters into a bank of
// NUM_ROWS accumulators. A start clears the bank one row per cycle, then products are summed
// until 'last' has been seen and the requesters have drained, after which done pulses once.
//
// Optional feature: define ROW_ACCUM_SAT_EN to make accumulation saturate at the signed
// max/min and add the sticky sat_flag output. Without it, accumulation wraps.
//
// Ports
//   clk, rst_l     : clock (rising edge), asynchronous active-low reset
//   start          : begin a new multiply (accepted in IDLE only)
//   last           : no further products once pending requests drain (latched)
//   req            : per-channel product valid
//   row_id         : per-channel destination row (held until granted)
//   product        : per-channel signed partial product (held until granted)
//   gnt            : one-hot combinational grant, only in ACCUM
//   busy           : high in CLEAR and ACCUM
//   done           : single-cycle completion pulse
//   rd_addr        : host readout address
//   rd_data        : registered accumulator at rd_addr, read-before-write
//   oob_err        : sticky, a granted row_id was >= NUM_ROWS
//   sat_flag       : sticky saturation indicator (ROW_ACCUM_SAT_EN only)
// ---------------------------------------------------------------------------------------------
module row_accum_arbiter
   import smvm_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
   parameter int unsigned NUM_ROWS     = NUM_ROWS_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst_l,
   input  logic                                  start,
   input  logic                                  last,
   input  logic [NUM_CHANNELS-1:0]               req,
   input  logic [NUM_CHANNELS-1:0][ROW_ID_W-1:0] row_id,
   input  logic [NUM_CHANNELS-1:0][DATA_W-1:0]   product,
   output logic [NUM_CHANNELS-1:0]               gnt,
   output logic                                  busy,
   output logic                                  done,
   input  logic [$clog2(NUM_ROWS)-1:0]           rd_addr,
   output logic [DATA_W-1:0]                     rd_data,
   output logic                                  oob_err
`ifdef ROW_ACCUM_SAT_EN
   ,
   output logic                                  sat_flag
`endif
);

   localparam int unsigned AW   = $clog2(NUM_ROWS);
   localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   state_e                  r_state, w_state_next;
   logic [AW-1:0]           r_clr_idx;
   logic [CH_W-1:0]         r_ptr, w_ptr_next;
   logic                    r_last;
   logic                    r_oob_err;
   logic [DATA_W-1:0]       r_acc [NUM_ROWS];
   logic [DATA_W-1:0]       r_rd_data;

   logic [NUM_CHANNELS-1:0] w_arb_gnt;
   logic                    w_start_ok;
   logic                    w_xfer;
   logic                    w_oob;
   logic [ROW_ID_W-1:0]     w_row;
   logic [AW-1:0]           w_row_idx;
   logic [DATA_W-1:0]       w_prod, w_old, w_sum, w_rd_val;

   rr_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .PTR_W        (CH_W)
   ) u_rr_arbiter (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt)
   );

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      gnt          = '0;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) w_state_next = StClear;
         end
         StClear: begin
            busy = 1'b1;
            if (r_clr_idx == AW'(NUM_ROWS - 1)) w_state_next = StAccum;
         end
         StAccum: begin
            busy = 1'b1;
            gnt  = w_arb_gnt;
            // Only the registered copy of last counts, so a same-cycle last waits one cycle.
            if (r_last && (req == '0)) w_state_next = StDone;
         end
         StDone: begin
            done         = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   assign w_start_ok = (r_state == StIdle) && start;

   // ------------------------------------------------------------------ transfer select
   always_comb begin
      w_row      = '0;
      w_prod     = '0;
      w_ptr_next = r_ptr;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (gnt[c]) begin
            w_row      = row_id[c];
            w_prod     = product[c];
            w_ptr_next = CH_W'((32'(c) + 32'd1) % NUM_CHANNELS);
         end
      end
   end

   assign w_xfer    = |(req & gnt);
   assign w_oob     = (w_row >= NUM_ROWS);
   assign w_row_idx = w_row[AW-1:0];
   assign w_old     = r_acc[w_row_idx];

`ifdef ROW_ACCUM_SAT_EN
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [DATA_W-1:0] w_raw;
   logic              w_sat;
   logic              r_sat_flag;

   assign w_raw = w_old + w_prod;
   // Overflow only when both operands share a sign that the raw sum does not.
   assign w_sat = (w_old[DATA_W-1] == w_prod[DATA_W-1]) &&
                  (w_raw[DATA_W-1] != w_old[DATA_W-1]);
   assign w_sum = w_sat ? (w_old[DATA_W-1] ? SAT_MIN : SAT_MAX) : w_raw;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_sat_flag <= 1'b0;
      end else if (w_start_ok) begin
         r_sat_flag <= 1'b0;
      end else if (w_xfer && !w_oob && w_sat) begin
         r_sat_flag <= 1'b1;
      end
   end

   assign sat_flag = r_sat_flag;
`else
   assign w_sum = w_old + w_prod;
`endif

   // ------------------------------------------------------------------ accumulator bank
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            r_acc[r] <= '0;
         end
      end else if (r_state == StClear) begin
         r_acc[r_clr_idx] <= '0;
      end else if (w_xfer && !w_oob) begin
         r_acc[w_row_idx] <= w_sum;
      end
   end

   // Out-of-range addresses (non power-of-two depth) read as zero.
   always_comb begin
      w_rd_val = '0;
      if (32'(rd_addr) < NUM_ROWS) w_rd_val = r_acc[rd_addr];
   end

   // ------------------------------------------------------------------ control registers
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_clr_idx <= '0;
         r_ptr     <= '0;
         r_last    <= 1'b0;
         r_oob_err <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_val;

         if (w_start_ok) begin
            r_clr_idx <= '0;
            r_oob_err <= 1'b0;
         end else if (r_state == StClear) begin
            r_clr_idx <= r_clr_idx + AW'(1);
         end

         if (r_state == StDone) begin
            r_last <= 1'b0;
         end else if (last && ((r_state == StClear) || (r_state == StAccum))) begin
            r_last <= 1'b1;
         end

         if (w_xfer) begin
            r_ptr <= w_ptr_next;
            // Out-of-range products are consumed but never written.
            if (w_oob) r_oob_err <= 1'b1;
         end
      end
   end

   assign rd_data = r_rd_data;
   assign oob_err = r_oob_err;

endmodule

// File: tb/tb_row_accum_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_row_accum_arbiter
// Self-checking bench for row_accum_arbiter with default parameters. A behavioural model
// (accumulator array, pointer, sticky flags, coarse phase) predicts grants, status and readout.
// Honours ROW_ACCUM_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------------------------
module tb_row_accum_arbiter;

   localparam int NCH   = 4;
   localparam int NROWS = 64;

   localparam int M_IDLE  = 0;
   localparam int M_CLEAR = 1;
   localparam int M_ACCUM = 2;
   localparam int M_DONE  = 3;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic             start = 1'b0;
   logic             last = 1'b0;
   logic [3:0]       req = '0;
   logic [3:0][31:0] row_id = '0;
   logic [3:0][31:0] product = '0;
   logic [3:0]       gnt;
   logic             busy;
   logic             done;
   logic [5:0]       rd_addr = '0;
   logic [31:0]      rd_data;
   logic             oob_err;
`ifdef ROW_ACCUM_SAT_EN
   logic             sat_flag;
`endif

   always #5 clk = ~clk;

   row_accum_arbiter dut (
      .clk     (clk),
      .rst_l   (rst_l),
      .start   (start),
      .last    (last),
      .req     (req),
      .row_id  (row_id),
      .product (product),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .oob_err (oob_err)
`ifdef ROW_ACCUM_SAT_EN
      ,
      .sat_flag(sat_flag)
`endif
   );

   int n_total = 0;
   int n_bad   = 0;

   // ----------------------------------------------------------------- reference model
   int          m_st;
   int          m_clr;
   int          m_ptr;
   bit          m_last;
   bit          m_oob;
   bit          m_sat;
   logic [31:0] m_acc [NROWS];
   logic [31:0] m_rd;
   logic [3:0]  e_gnt;
   bit          e_busy;
   bit          e_done;

   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           output bit sat);
      longint s;
      longint smax;
      longint smin;
      smax = 64'sd2147483647;
      smin = -smax - 64'sd1;
      s    = longint'($signed(a)) + longint'($signed(b));
      sat  = 1'b0;
`ifdef ROW_ACCUM_SAT_EN
      if (s > smax) begin
         s = smax; sat = 1'b1;
      end else if (s < smin) begin
         s = smin; sat = 1'b1;
      end
`endif
      return s[31:0];
   endfunction

   function automatic void model_reset();
      m_st = M_IDLE; m_clr = 0; m_ptr = 0; m_last = 0; m_oob = 0; m_sat = 0; m_rd = '0;
      for (int r = 0; r < NROWS; r++) m_acc[r] = '0;
   endfunction

   // Expected combinational outputs for the inputs currently driven.
   function automatic void model_comb();
      int ch;
      bit found;
      found  = 0;
      e_gnt  = '0;
      e_busy = (m_st == M_CLEAR) || (m_st == M_ACCUM);
      e_done = (m_st == M_DONE);
      if (m_st == M_ACCUM) begin
         for (int k = 0; k < NCH; k++) begin
            ch = (m_ptr + k) % NCH;
            if (!found && req[ch]) begin
               e_gnt[ch] = 1'b1;
               found     = 1;
            end
         end
      end
   endfunction

   // Advance model and DUT through one rising edge; returns at edge + 1.
   task automatic step();
      logic [31:0] rd_next;
      int          nxt;
      bit          s;
      model_comb();
      rd_next = m_acc[rd_addr];
      nxt     = m_st;
      case (m_st)
         M_IDLE: if (start) begin
            nxt = M_CLEAR; m_clr = 0; m_oob = 0; m_sat = 0;
         end
         M_CLEAR: begin
            m_acc[m_clr] = '0;
            m_clr++;
            if (m_clr == NROWS) nxt = M_ACCUM;
            if (last) m_last = 1;
         end
         M_ACCUM: begin
            for (int c = 0; c < NCH; c++) begin
               if (e_gnt[c]) begin
                  if (row_id[c] >= NROWS) m_oob = 1;
                  else begin
                     m_acc[row_id[c]] = ref_add(m_acc[row_id[c]], product[c], s);
                     if (s) m_sat = 1;
                  end
                  m_ptr = (c + 1) % NCH;
               end
            end
            if (m_last && (req == '0)) nxt = M_DONE;
            if (last) m_last = 1;
         end
         M_DONE: begin
            m_last = 0; nxt = M_IDLE;
         end
         default: nxt = M_IDLE;
      endcase
      m_st = nxt;
      @(posedge clk);
      #1;
      m_rd = rd_next;
   endtask

   task automatic settle();
      #1;
      model_comb();
   endtask

   task automatic refresh_granted();
      for (int c = 0; c < NCH; c++) begin
         if (e_gnt[c]) begin
            row_id[c]  = $urandom_range(0, NROWS - 1);
            product[c] = $urandom;
         end
      end
   endtask

   task automatic run_clear();
      start = 1'b1; settle(); step(); start = 1'b0;
      for (int i = 0; i < NROWS; i++) begin
         settle(); step();
      end
   endtask

   task automatic finish_op(output bit seen);
      req = '0; last = 1'b1; settle(); step(); last = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         settle();
         if (done === 1'b1) seen = 1;
         step();
         if (seen) break;
      end
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      rst_l = 1'b0; model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_total++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_total++; if (gnt !== 4'h0) begin n_bad++; $display("FAIL reset_gnt: got %h want 0", gnt); end
      n_total++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", rd_data); end
      n_total++; if (oob_err !== 1'b0) begin n_bad++; $display("FAIL reset_oob: got %b want 0", oob_err); end
`ifdef ROW_ACCUM_SAT_EN
      n_total++; if (sat_flag !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
`endif
      @(negedge clk); rst_l = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_clear();
      int busy_cnt;
      busy_cnt = 0;
      start = 1'b1; settle();
      n_total++; if (busy !== e_busy) begin n_bad++; $display("FAIL clear_idle_busy: got %b want %b", busy, e_busy); end
      step(); start = 1'b0;
      for (int i = 0; i < NROWS; i++) begin
         req = 4'hF; rd_addr = 6'(i); settle();
         n_total++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL clear_gnt[%0d]: got %h want %h", i, gnt, e_gnt); end
         if (busy === 1'b1) busy_cnt++;
         step();
         n_total++; if (rd_data !== m_rd) begin n_bad++; $display("FAIL clear_rd[%0d]: got %h want %h", i, rd_data, m_rd); end
      end
      req = '0; settle();
      n_total++; if (busy_cnt !== NROWS) begin n_bad++; $display("FAIL clear_busy_cycles: got %0d want %0d", busy_cnt, NROWS); end
      n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL accum_busy: got %b want 1", busy); end
   endtask

   task automatic test_all_four();
      logic [3:0] oh;
      req = 4'hF;
      for (int k = 0; k < NCH; k++) begin
         row_id[k] = 32'd3; product[k] = 32'(k + 1);
      end
      for (int k = 0; k < NCH; k++) begin
         settle();
         oh = 4'(1 << k);
         n_total++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL four_gnt[%0d]: got %h want %h", k, gnt, e_gnt); end
         n_total++; if (gnt !== oh) begin n_bad++; $display("FAIL four_order[%0d]: got %h want %h", k, gnt, oh); end
         step();
         req[k] = 1'b0;
      end
      rd_addr = 6'd3; settle(); step();
      n_total++; if (rd_data !== m_rd) begin n_bad++; $display("FAIL four_acc_model: got %h want %h", rd_data, m_rd); end
      n_total++; if (rd_data !== 32'd10) begin n_bad++; $display("FAIL four_acc3: got %h want a", rd_data); end
   endtask

   task automatic test_rr_order();
      logic [3:0] order [4];
      order = '{4'h8, 4'h2, 4'h8, 4'h2};
      // A lone grant to channel 1 moves the pointer to 2.
      req = 4'b0010; row_id[1] = 32'd5; product[1] = 32'd7; settle();
      n_total++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rr_setup: got %h want 2", gnt); end
      step(); refresh_granted();
      req = 4'b1010;
      row_id[3] = $urandom_range(0, NROWS - 1); product[3] = $urandom;
      for (int k = 0; k < 4; k++) begin
         settle();
         n_total++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL rr_model[%0d]: got %h want %h", k, gnt, e_gnt); end
         n_total++; if (gnt !== order[k]) begin n_bad++; $display("FAIL rr_order[%0d]: got %h want %h", k, gnt, order[k]); end
         step(); refresh_granted();
      end
      req = '0;
   endtask

   task automatic test_last_done();
      req = 4'b0001; row_id[0] = 32'd9; product[0] = 32'd11; last = 1'b1; settle();
      n_total++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL last_gnt: got %h want 1", gnt); end
      step(); req = '0; last = 1'b0;
      settle();
      n_total++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL last_drain: got done=%b busy=%b want 0 1", done, busy); end
      step(); settle();
      n_total++; if (done !== 1'b1 || done !== e_done) begin n_bad++; $display("FAIL last_done: got %b want 1", done); end
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL last_done_busy: got %b want 0", busy); end
      step(); settle();
      n_total++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL last_idle: got done=%b busy=%b want 0 0", done, busy); end
      n_total++; if (e_busy !== 1'b0) begin n_bad++; $display("FAIL last_model_idle: got %b want 0", e_busy); end
   endtask

   task automatic test_oob();
      bit seen;
      run_clear();
      req = 4'b0001; row_id[0] = 32'd64; product[0] = 32'd5; settle();
      n_total++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL oob_gnt: got %h want %h", gnt, e_gnt); end
      step(); req = '0;
      n_total++; if (oob_err !== 1'b1) begin n_bad++; $display("FAIL oob_set: got %b want 1", oob_err); end
      rd_addr = 6'd0; settle(); step();
      n_total++; if (rd_data !== 32'h0 || rd_data !== m_rd) begin n_bad++; $display("FAIL oob_nowrite: got %h want 0", rd_data); end
      req = 4'b0001; row_id[0] = 32'd2; product[0] = 32'd3; settle(); step(); req = '0;
      n_total++; if (oob_err !== 1'b1) begin n_bad++; $display("FAIL oob_sticky: got %b want 1", oob_err); end
      finish_op(seen);
      n_total++; if (!seen) begin n_bad++; $display("FAIL oob_done_timeout: got no done want done"); end
      start = 1'b1; settle(); step(); start = 1'b0;
      n_total++; if (oob_err !== 1'b0) begin n_bad++; $display("FAIL oob_clear: got %b want 0", oob_err); end
      for (int i = 0; i < NROWS; i++) begin
         settle(); step();
      end
   endtask

   task automatic test_sat();
      logic [31:0] want0, want1;
`ifdef ROW_ACCUM_SAT_EN
      want0 = 32'h7FFFFFFF; want1 = 32'h80000000;
`else
      want0 = 32'h80000010; want1 = 32'h7FFFFFF0;
`endif
      req = 4'b0001; row_id[0] = 32'd0; product[0] = 32'h7FFFFFF0; settle(); step();
      product[0] = 32'h20; settle(); step();
      row_id[0] = 32'd1; product[0] = 32'h80000010; settle(); step();
      product[0] = 32'hFFFFFFE0; settle(); step(); req = '0;
      rd_addr = 6'd0; settle(); step();
      n_total++; if (rd_data !== want0 || rd_data !== m_rd) begin n_bad++; $display("FAIL sat_pos: got %h want %h", rd_data, want0); end
      rd_addr = 6'd1; settle(); step();
      n_total++; if (rd_data !== want1 || rd_data !== m_rd) begin n_bad++; $display("FAIL sat_neg: got %h want %h", rd_data, want1); end
`ifdef ROW_ACCUM_SAT_EN
      n_total++; if (sat_flag !== 1'b1) begin n_bad++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
`endif
   endtask

   task automatic test_random();
      bit seen;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < NCH; c++) begin
            if (!req[c] && $urandom_range(0, 1) == 1) begin
               req[c]     = 1'b1;
               row_id[c]  = ($urandom_range(0, 15) == 0) ? $urandom_range(64, 100)
                                                         : $urandom_range(0, NROWS - 1);
               product[c] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 255);
            end
         end
         start   = ($urandom_range(0, 15) == 0);
         rd_addr = 6'($urandom_range(0, NROWS - 1));
         settle();
         n_total++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL rand_gnt[%0d]: got %h want %h", cyc, gnt, e_gnt); end
         n_total++; if (busy !== e_busy || done !== e_done) begin n_bad++; $display("FAIL rand_status[%0d]: got %b%b want %b%b", cyc, busy, done, e_busy, e_done); end
         step();
         n_total++; if (rd_data !== m_rd) begin n_bad++; $display("FAIL rand_rd[%0d]: got %h want %h", cyc, rd_data, m_rd); end
         n_total++; if (oob_err !== m_oob) begin n_bad++; $display("FAIL rand_oob[%0d]: got %b want %b", cyc, oob_err, m_oob); end
`ifdef ROW_ACCUM_SAT_EN
         n_total++; if (sat_flag !== m_sat) begin n_bad++; $display("FAIL rand_sat[%0d]: got %b want %b", cyc, sat_flag, m_sat); end
`endif
         req = req & ~e_gnt;
      end
      start = 1'b0;
      finish_op(seen);
      n_total++; if (!seen) begin n_bad++; $display("FAIL rand_done_timeout: got no done want done"); end
      for (int r = 0; r < NROWS; r++) begin
         rd_addr = 6'(r); settle(); step();
         n_total++; if (rd_data !== m_rd) begin n_bad++; $display("FAIL rand_dump[%0d]: got %h want %h", r, rd_data, m_rd); end
      end
   endtask

   task automatic test_clear_again();
      start = 1'b1; settle(); step(); start = 1'b0;
      for (int i = 0; i < NROWS; i++) begin
         rd_addr = 6'(NROWS - 1 - i); settle();
         n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reclear_busy[%0d]: got %b want 1", i, busy); end
         step();
         n_total++; if (rd_data !== m_rd) begin n_bad++; $display("FAIL reclear_rd[%0d]: got %h want %h", i, rd_data, m_rd); end
      end
      for (int r = 0; r < NROWS; r++) begin
         rd_addr = 6'(r); settle(); step();
         n_total++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reclear_zero[%0d]: got %h want 0", r, rd_data); end
      end
   endtask

   task automatic test_reset_mid();
      req = 4'b0011;
      row_id[0] = 32'd4; product[0] = 32'd100;
      row_id[1] = 32'd4; product[1] = 32'd200;
      settle(); step(); settle();
      rst_l = 1'b0; #1;
      model_reset();
      n_total++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: got %b%b want 00", busy, done); end
      n_total++; if (gnt !== 4'h0) begin n_bad++; $display("FAIL rstmid_gnt: got %h want 0", gnt); end
      n_total++; if (rd_data !== 32'h0 || oob_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_regs: got %h %b want 0 0", rd_data, oob_err); end
      @(negedge clk); rst_l = 1'b1;
      @(posedge clk); #1;
      rd_addr = 6'd4;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_total++; if (gnt !== e_gnt || done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle[%0d]: got %h %b%b want %h 00", i, gnt, busy, done, e_gnt); end
         step();
         n_total++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_acc[%0d]: got %h want 0", i, rd_data); end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_clear();
      test_all_four();
      test_rr_order();
      test_last_done();
      test_oob();
      test_sat();
      test_random();
      test_clear_again();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
